seq_divider: RTL

- Multi-cycle restoring divider. Computes the inverse of the multiply path of the existing combinational add/sub/mul unit.
- Accepts a 6-bit dividend and divisor on a start pulse and returns quotient and remainder with a one-cycle done strobe.
- Sits beside the combinational unit in the arithmetic datapath. The control FSM issues operands and collects results through the start/done handshake.

---
 rtl/seq_divider.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: WIDTH clock steps per quotient, start/done handshake.
// Define DIV_SIGNED_EN for two's complement operands (truncating division); default is unsigned.
module seq_divider #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    // One restoring step: shift {rem,dvd} left, keep the trial difference when it does not borrow
    always_comb begin
        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, div_q};
        step_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        step_dvd = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    end

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // The core works on magnitudes; the most-negative value still fits as an unsigned magnitude
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign q_res = neg_q_q ? (~step_dvd + WIDTH'(1)) : step_dvd;
    assign r_res = neg_r_q ? (~step_rem + WIDTH'(1)) : step_rem;

    always_comb begin
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            neg_q_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_d = a[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`else
    assign a_mag = a;
    assign b_mag = b;
    assign q_res = step_dvd;
    assign r_res = step_rem;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    dvd_d = a_mag;
                    div_d = b_mag;
                    rem_d = '0;
                    cnt_d = '0;
                    if (b == '0) begin
                        // Divide-by-zero skips the datapath and reports immediately
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        q_d     = '1;
                        r_d     = a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                rem_d  = step_rem;
                dvd_d  = step_dvd;
                busy_d = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = q_res;
                    r_d     = r_res;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule
